// File: rtl/config_latch_bank_writer.sv
// config_latch_bank_writer: drives bit lines, then pulses one word line per accepted configuration word
module config_latch_bank_writer #(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_WL          = 16,
    parameter int ADDR_WIDTH      = 4,
    parameter int WL_PULSE_CYCLES = 2
) (
    input  logic                  prog_clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_last,
    output logic [DATA_WIDTH-1:0] bl,
    output logic [NUM_WL-1:0]     wl,
    output logic                  busy,
    output logic                  done,
    output logic                  addr_err
);
    localparam int CW = $clog2(WL_PULSE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    last_q;
    logic [CW-1:0]           cnt;
    logic                    hs;
    logic                    in_range;
    logic [NUM_WL-1:0]       wl_hot;

    assign cfg_ready = (state == IDLE) && !reset;
    assign hs        = cfg_valid && cfg_ready;
    assign in_range  = 32'(cfg_addr) < NUM_WL;
    assign wl_hot    = NUM_WL'(1) << addr_q;
    assign busy      = (state == SETUP) || (state == PULSE) || (state == HOLD);
    assign done      = (state == DONE);

    // State register; reset aborts any write in flight
    always_ff @(posedge prog_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Sequence: handshake -> SETUP -> PULSE x N -> HOLD -> IDLE/DONE; bad addresses skip the pulse
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (hs) state_n = in_range ? SETUP : (cfg_last ? DONE : IDLE);
            SETUP:   state_n = PULSE;
            PULSE:   state_n = (cnt == CW'(1)) ? HOLD : PULSE;
            HOLD:    state_n = last_q ? DONE : IDLE;
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Registered datapath: bl loads only on the handshake edge (wl is low then), wl follows next state
    always_ff @(posedge prog_clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            last_q   <= 1'b0;
            bl       <= '0;
            wl       <= '0;
            cnt      <= '0;
            addr_err <= 1'b0;
        end else begin
            if (hs) begin
                addr_q <= cfg_addr;
                last_q <= cfg_last;
                if (in_range) bl <= cfg_data;
                else          addr_err <= 1'b1;
            end
            cnt <= (state == SETUP) ? CW'(WL_PULSE_CYCLES) : (state == PULSE) ? cnt - CW'(1) : cnt;
            wl  <= (state_n == PULSE) ? wl_hot : '0;
        end
    end
endmodule

// File: tb/tb_config_latch_bank_writer.sv
// tb_config_latch_bank_writer: scoreboard bench over three parameter sets of the latch bank writer
module tb_config_latch_bank_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input int g, input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cfg%0d %s: got %0h, expected %0h", g, n, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int N = (g == 0) ? 16 : 12;
        localparam int P = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        logic         r = 1'b1, vld = 1'b0, last = 1'b0;
        logic         rdy, busy, done, aerr;
        logic [3:0]   addr = '0;
        logic [7:0]   data = '0, bl;
        logic [N-1:0] wl;

        int  qa[$], qd[$];
        int  ea, ed, plen = 0;
        bit  fin = 0, aerr_m = 0, done_m = 0, have_prev = 0, prev_in = 0;
        time prev_t = 0;
        logic [N-1:0] pw = '0;
        logic [7:0]   pbl = '0;

        config_latch_bank_writer #(
            .DATA_WIDTH(8), .NUM_WL(N), .ADDR_WIDTH(4), .WL_PULSE_CYCLES(P)
        ) dut (
            .prog_clk(clk), .reset(r), .cfg_valid(vld), .cfg_ready(rdy),
            .cfg_addr(addr), .cfg_data(data), .cfg_last(last),
            .bl(bl), .wl(wl), .busy(busy), .done(done), .addr_err(aerr)
        );

        // Offer one word; on handshake record the expected effect and check spacing from the previous one
        task automatic send(input int a, input int d, input bit l, input int gap);
            bit  ok = 0;
            time t;
            vld = 1'b0;
            repeat (gap) @(negedge clk);
            addr = 4'(a); data = 8'(d); last = l; vld = 1'b1;
            for (int i = 0; i < 40 && !ok; i++) begin
                if (rdy) ok = 1;
                else @(negedge clk);
            end
            chk(g, "handshake", 64'(ok), 1);
            if (ok) begin
                @(posedge clk);
                t = $time;
                if (a < N) begin
                    qa.push_back(a);
                    qd.push_back(d & 255);
                end else aerr_m = 1;
                if (l) done_m = 1;
                if (gap == 0 && have_prev) chk(g, "spacing", 64'((t - prev_t) / 10), prev_in ? P + 3 : 1);
                prev_t = t; prev_in = (a < N); have_prev = 1;
                @(negedge clk);
            end else have_prev = 0;
            vld = 1'b0;
        endtask

        task automatic settle();
            bit ok = 0;
            for (int i = 0; i < 40 && !ok; i++) begin
                if (!busy) ok = 1;
                else @(negedge clk);
            end
            chk(g, "settle", 64'(ok), 1);
            chk(g, "pending_writes", 64'(qa.size()), 0);
            chk(g, "done", 64'(done), 64'(done_m));
            chk(g, "addr_err", 64'(aerr), 64'(aerr_m));
            chk(g, "ready", 64'(rdy), 64'(!done_m));
            have_prev = 0;
        endtask

        initial begin
            repeat (3) @(negedge clk);
            chk(g, "reset_wl", 64'(wl), 0);
            chk(g, "reset_bl", 64'(bl), 0);
            chk(g, "reset_busy", 64'(busy), 0);
            chk(g, "reset_done", 64'(done), 0);
            chk(g, "reset_addr_err", 64'(aerr), 0);
            r = 1'b0;
            #1 chk(g, "ready_after_reset", 64'(rdy), 1);
            send(3, 'hA5, 0, 0);
            settle();
            repeat (12) send(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), 0, int'($urandom_range(0, 2)));
            settle();
            send(15, 'h3C, 0, 0);
            send(0, 'hC3, 0, 0);
            settle();
            send(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 255)), 0, 0);
            for (int i = 0; i < 10 && wl == '0; i++) @(negedge clk);
            chk(g, "pulse_seen", 64'(wl != '0), 1);
            #2 r = 1'b1;
            #1;
            chk(g, "async_wl", 64'(wl), 0);
            chk(g, "async_bl", 64'(bl), 0);
            chk(g, "async_busy", 64'(busy), 0);
            qa.delete(); qd.delete();
            aerr_m = 0; done_m = 0; have_prev = 0;
            @(negedge clk) r = 1'b0;
            #1;
            chk(g, "ready_after_abort", 64'(rdy), 1);
            chk(g, "done_after_abort", 64'(done), 0);
            chk(g, "addr_err_after_abort", 64'(aerr), 0);
            for (int i = 0; i < N; i++) send(i, (g == 0) ? i : int'($urandom_range(0, 255)), i == N - 1, 0);
            settle();
            addr = 4'd1; data = 8'h5A; last = 1'b0; vld = 1'b1;
            repeat (5) begin
                @(negedge clk);
                chk(g, "ready_in_done", 64'(rdy), 0);
                chk(g, "done_sticky", 64'(done), 1);
            end
            vld = 1'b0;
            fin = 1;
        end

        // Monitor: each wl pulse must match the oldest outstanding write and respect setup/hold/width
        initial forever begin
            @(negedge clk);
            if (r) begin
                pw = '0;
                plen = 0;
            end else begin
                chk(g, "onehot0", 64'($onehot0(wl)), 1);
                if (pw != '0) chk(g, "bl_stable", 64'(bl), 64'(pbl));
                if (wl != '0) begin
                    chk(g, "busy_in_pulse", 64'(busy), 1);
                    chk(g, "ready_in_pulse", 64'(rdy), 0);
                end
                if (wl != '0 && pw == '0) begin
                    if (qa.size() == 0) chk(g, "unexpected_pulse", 64'(wl), 0);
                    else begin
                        ea = qa.pop_front();
                        ed = qd.pop_front();
                        chk(g, "wl_select", 64'(wl), 64'(1) << ea);
                        chk(g, "bl_data", 64'(bl), 64'(ed));
                        chk(g, "bl_setup", 64'(pbl), 64'(bl));
                    end
                    plen = 1;
                end else if (wl != '0) begin
                    chk(g, "wl_steady", 64'(wl), 64'(pw));
                    plen++;
                end else if (pw != '0) chk(g, "pulse_len", 64'(plen), 64'(P));
                pw  = wl;
                pbl = bl;
            end
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(cfg[0].fin && cfg[1].fin && cfg[2].fin); i++) @(negedge clk);
        chk(9, "all_finished", 64'(cfg[0].fin && cfg[1].fin && cfg[2].fin), 1);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
